// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add and one right shift per cycle.
// Takes DATA_WIDTH cycles per product and holds the result until the next accepted start.
module shift_add_multiplier #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] multiplicand,
    input  logic [DATA_WIDTH-1:0] multiplier,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product_hi,
    output logic [DATA_WIDTH-1:0] product_lo
);

    localparam int unsigned CntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;

    logic [DATA_WIDTH-1:0] addend;
    logic [DATA_WIDTH-1:0] sum;
    logic                  carry_out;

    // The shared adder: the multiplier bit currently in acc_lo[0] gates the multiplicand.
    assign addend           = acc_lo_q[0] ? mcand_q : '0;
    assign {carry_out, sum} = {1'b0, acc_hi_q} + {1'b0, addend};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mcand_d  = mcand_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = multiplicand;
                    acc_lo_d = multiplier;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                // Carry lands in the top bit so the 2W-bit product never wraps.
                {acc_hi_d, acc_lo_d} = {carry_out, sum, acc_lo_q[DATA_WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mcand_q  <= mcand_d;
        end
    end

    assign ready      = (state_q == StIdle);
    assign busy       = (state_q == StRun) || (state_q == StDone);
    assign done       = (state_q == StDone);
    assign product_hi = acc_hi_q;
    assign product_lo = acc_lo_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed table, protocol sequences,
// and random operands compared against a plain 2W-bit multiply.
module tb_shift_add_multiplier;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] multiplicand = '0;
    logic [W-1:0] multiplier = '0;
    logic         ready, busy, done;
    logic [W-1:0] product_hi, product_lo;

    int n_checks = 0;
    int n_errors = 0;

    shift_add_multiplier #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product_hi   (product_hi),
        .product_lo   (product_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } vec_t;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa;
        logic [2*W-1:0] wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0:       r = '0;
            1:       r = '1;
            2:       r = r >> $urandom_range(1, W - 1);
            default: ;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < W + 10 && !ready; i++) tick();
        check({name, "_ready_timeout"}, 128'(ready), 128'(1));
    endtask

    // Runs one product. poke_at drives an ignored 2*2 request at that RUN cycle;
    // reset_at instead aborts the operation at that RUN cycle.
    task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                           input int poke_at, input int reset_at);
        int lat;
        int n_done;
        wait_ready(name);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        check({name, "_accept_busy"}, 128'(busy), 128'(1));
        start        = 1'b0;
        multiplicand = rand_word();
        multiplier   = rand_word();
        lat = -1;
        for (int i = 1; i <= W + 4; i++) begin
            if (i == poke_at) begin
                start        = 1'b1;
                multiplicand = 2;
                multiplier   = 2;
            end
            if (i == reset_at) reset = 1'b1;
            tick();
            start = 1'b0;
            if (i == reset_at) begin
                reset = 1'b0;
                check({name, "_rst_flags"}, 128'({ready, busy, done}), 128'(3'b100));
                check({name, "_rst_product"}, {product_hi, product_lo}, '0);
                n_done = 0;
                for (int j = 0; j < W + 4; j++) begin
                    tick();
                    if (done) n_done++;
                end
                check({name, "_rst_no_done"}, 128'(n_done), 128'(0));
                return;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, 128'(lat), 128'(W));
        check({name, "_product"}, {product_hi, product_lo}, {exp_hi, exp_lo});
        check({name, "_done_busy"}, 128'({ready, busy}), 128'(2'b01));
        tick();
        check({name, "_done_pulse"}, 128'({ready, busy, done}), 128'(3'b100));
        check({name, "_held"}, {product_hi, product_lo}, {exp_hi, exp_lo});
    endtask

    vec_t vecs[5];

    initial begin
        logic [2*W-1:0] exp;
        logic [W-1:0]   a, b;
        int             t, prev_t, n_done, n_bad_ii;

        vecs[0] = '{64'd3, 64'd5, 64'd0, 64'd15, "mul_3x5"};
        vecs[1] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, "mul_0xmax"};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, "mul_maxxmax"};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd2, 64'd1, 64'd0, "mul_carry"};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, "mul_maxx0"};

        // Reset held for two edges with start asserted: nothing may be accepted.
        reset        = 1'b1;
        start        = 1'b1;
        multiplicand = 3;
        multiplier   = 5;
        tick();
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("reset_flags", 128'({ready, busy, done}), 128'(3'b100));
        check("reset_product", {product_hi, product_lo}, '0);
        tick();
        check("reset_start_ignored", 128'({ready, busy}), 128'(2'b10));

        foreach (vecs[i])
            run_mul(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, -1, -1);

        // Busy protocol, then abort and recovery.
        run_mul("busy_7x9", 64'd7, 64'd9, 64'd0, 64'd63, 10, -1);
        run_mul("abort", 64'd11, 64'd13, 64'd0, 64'd0, -1, 30);
        run_mul("after_abort_6x7", 64'd6, 64'd7, 64'd0, 64'd42, -1, -1);

        // start held high: one accept per W+2 cycles, each result correct.
        wait_ready("b2b");
        a = rand_word();
        b = rand_word();
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        t = 0;
        prev_t = -1;
        n_done = 0;
        n_bad_ii = 0;
        while (n_done < 3 && t < 4 * (W + 2) + 10) begin
            tick();
            t++;
            if (done) begin
                exp = model(a, b);
                check("b2b_product", {product_hi, product_lo}, exp);
                if (prev_t >= 0 && t - prev_t != W + 2) n_bad_ii++;
                prev_t = t;
                n_done++;
                if (n_done == 3) start = 1'b0;
                a = rand_word();
                b = rand_word();
                multiplicand = a;
                multiplier   = b;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 128'(n_done), 128'(3));
        check("b2b_interval", 128'(n_bad_ii), 128'(0));

        for (int i = 0; i < 150; i++) begin
            a   = rand_word();
            b   = rand_word();
            exp = model(a, b);
            run_mul("rand", a, b, exp[2*W-1:W], exp[W-1:0], -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
